// File: rtl/int_sub_pkg.sv
// Shared types and default sizing for the sequential integer subtractor.
// Other files import this package.
package int_sub_pkg;

  localparam int N_DEF     = 32;
  localparam int CHUNK_DEF = 4;
  localparam int NCH_DEF   = N_DEF / CHUNK_DEF;
  localparam int IDX_W_DEF = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_chunk_cla.sv
// Combinational carry-lookahead slice. Each carry is expanded directly from
// the generate/propagate terms and cin, rather than rippled bit by bit.
module sub_chunk_cla #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         pp;
  logic         cc;

  assign g = x & y;
  assign p = x ^ y;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    c    = '0;
    c[0] = cin;
    pp   = 1'b1;
    cc   = 1'b0;
    for (int i = 0; i < W; i++) begin
      pp = 1'b1;
      cc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
  end

  assign s    = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/int_sub_seq.sv
// Multi-cycle subtractor diff = a - b: one CHUNK-bit lookahead slice per
// clock, computed as a + ~b + 1, with valid/ready on both sides.
module int_sub_seq
  import int_sub_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int NCH   = N / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [N-1:0]       a_r;
  logic [N-1:0]       b_r;
  logic [CHUNK-1:0]   slice_s;
  logic               slice_cout;
  logic [N-1:0]       diff_next;

  sub_chunk_cla #(.W(CHUNK)) u_cla (
    .x    (a_r[idx*CHUNK +: CHUNK]),
    .y    (b_r[idx*CHUNK +: CHUNK]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign in_ready = (state == IDLE) & ~rst;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full result as it will look once the current slice is written back.
  always_comb begin
    diff_next = diff;
    diff_next[idx*CHUNK +: CHUNK] = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b1;
      a_r       <= '0;
      b_r       <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= ~b;
            carry <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            borrow    <= ~slice_cout;
            zero      <= (diff_next == '0);
            neg       <= diff_next[N-1];
            // b_r holds ~b, so equal top bits mean the operand signs differ
            ovf       <= (a_r[N-1] == b_r[N-1]) & (diff_next[N-1] != a_r[N-1]);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_sub_seq.sv
// Bench for int_sub_seq: arithmetic reference model with per-cycle compare,
// plus directed operations with hand-computed expectations.
module tb_int_sub_seq;

  localparam int N   = 32;
  localparam int NCH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  diff;
  logic          borrow, zero, neg, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int_sub_seq #(.N(N), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of accepted operands, expected results by arithmetic.
  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           acc;
  } op_t;

  op_t          q[$];
  op_t          cur;
  bit           seen = 0;
  logic [N-1:0] e_diff;
  longint       r_wide;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL model_spurious_valid got=1 want=0 (t=%0t)", $time);
        end else begin
          cur    = q[0];
          e_diff = cur.a - cur.b;
          r_wide = longint'($signed(cur.a)) - longint'($signed(cur.b));
          chk("model_diff",   diff,   e_diff);
          chk("model_borrow", {31'b0, borrow}, {31'b0, (cur.a < cur.b)});
          chk("model_zero",   {31'b0, zero},   {31'b0, (e_diff == '0)});
          chk("model_neg",    {31'b0, neg},    {31'b0, e_diff[N-1]});
          chk("model_ovf",    {31'b0, ovf},    {31'b0, (r_wide != longint'($signed(e_diff)))});
          chk("model_in_ready_busy", {31'b0, in_ready}, 32'd0);
          if (!seen) begin
            chk("model_latency", 32'(cyc - cur.acc), 32'(NCH));
            seen = 1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{a, b, cyc + 1});
    end
  end

  task automatic wait_accept(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_accept_timeout got=0 want=1", tag);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_valid_timeout got=0 want=1", tag);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] ed,
                        input logic eb, input logic ez, input logic en, input logic eo,
                        input string tag);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    wait_accept(tag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_valid(tag);
    chk({tag, "_diff"},   diff, ed);
    chk({tag, "_borrow"}, {31'b0, borrow}, {31'b0, eb});
    chk({tag, "_zero"},   {31'b0, zero},   {31'b0, ez});
    chk({tag, "_neg"},    {31'b0, neg},    {31'b0, en});
    chk({tag, "_ovf"},    {31'b0, ovf},    {31'b0, eo});
    $display("op %s a=%h b=%h diff=%h borrow=%0b zero=%0b neg=%0b ovf=%0b",
             tag, ta, tb, diff, borrow, zero, neg, ovf);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff",      diff, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd0);
    chk("rst_flags",     {28'b0, borrow, zero, neg, ovf}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    run_op(32'd5, 32'd3, 32'h0000_0002, 0, 0, 0, 0, "t1");
    run_op(32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0, 1, 0, "t2");
    run_op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 0, 0, 1, "t3a");
    run_op(32'h0001_0000, 32'd1, 32'h0000_FFFF, 0, 0, 0, 0, "t3b");
    run_op(32'h1234_5678, 32'h1234_5678, 32'h0, 0, 1, 0, 0, "t4");
    run_op(32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 0, 0, 1, 0, "bzero");

    // Backpressure: hold the result while new operands wait on the input.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 32'd100;
    b = 32'd7;
    out_ready = 1'b0;
    wait_accept("t5a");
    @(posedge clk);
    #1;
    a = 32'd200;
    b = 32'd50;
    wait_valid("t5a");
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_diff",     diff, 32'd93);
      chk("t5_hold_valid",    {31'b0, out_valid}, 32'd1);
      chk("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
      $display("op t5 hold cycle %0d diff=%h in_ready=%0b", i, diff, in_ready);
      @(posedge clk);
      #1;
      if (i < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t5_idle_valid",    {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid("t5b");
    chk("t5b_diff", diff, 32'd150);
    $display("op t5b a=%h b=%h diff=%h", 32'd200, 32'd50, diff);
    @(posedge clk);

    // Reset in the middle of RUN, after three slices are written.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'd0;
    wait_accept("t6");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",    {31'b0, out_valid}, 32'd0);
    chk("t6_rst_diff",     diff, 32'd0);
    chk("t6_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rel_in_ready", {31'b0, in_ready}, 32'd1);
    $display("op t6 reset mid-run diff=%h in_ready=%0b", diff, in_ready);
    run_op(32'd10, 32'd20, 32'hFFFF_FFF6, 1, 0, 1, 0, "t6b");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_sub_seq.md
Name: int_sub_seq

Overview:
- Multi-cycle two's-complement integer subtractor, diff = a - b. It is the inverse operation to the team's combinational carry-lookahead integer adder.
- Processes CHUNK bits per clock with a carry-lookahead slice. The carry-in of the first slice is 1, and b is inverted.
- Uses valid/ready handshakes on both sides.
- Feeds the float adder's exponent-difference and mantissa-subtract paths where area matters more than latency.

Parameters:
- N, 32, operand/result width.
- CHUNK, 4, bits resolved per cycle. Must divide N.
- Derived constant NCH = N/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  N  minuend.
- b  in  N  subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  N  a - b, modulo 2^N.
- borrow  out  1  unsigned borrow, equal to ~carry_out; set when a < b unsigned.
- zero  out  1  diff == 0.
- neg  out  1  diff[N-1].
- ovf  out  1  signed overflow.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (asynchronous, while rst high):
  - state = IDLE, chunk index = 0, carry = 1.
  - diff, borrow, zero, neg, ovf, out_valid all 0.
  - in_ready = (state == IDLE) & ~rst, so it is 0 while rst is high.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1: latch a into A_r and ~b into B_r, set carry = 1, index = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge computes slice k = index, bits [k*CHUNK +: CHUNK]:
    - g = A_r & B_r, p = A_r ^ B_r.
    - Lookahead carries within the slice from the registered carry.
    - Slice sum is written into diff[k*CHUNK +: CHUNK].
    - carry is updated to the slice carry-out, index increments.
  - On the edge that processes slice NCH-1, go to DONE. On that same edge register:
    - borrow = ~carry_out.
    - zero = (full diff == 0).
    - neg = diff[N-1].
    - ovf = (a[N-1] != b[N-1]) & (diff[N-1] != a[N-1]).
    - out_valid = 1.
- Latency: out_valid rises exactly NCH edges after the accepting edge (8 for the defaults).
- DONE:
  - out_valid = 1. All result outputs are held stable.
  - On an edge with out_ready=1: out_valid = 0, go to IDLE.
  - No same-edge accept of new operands. Throughput is one operation per NCH+2 cycles minimum.
- Boundaries:
  - in_valid while in RUN/DONE: ignored and not accepted; in_ready=0.
  - out_ready outside DONE: ignored.
  - Operands may change after the accepting edge without effect.
  - diff bits of not-yet-processed slices are unspecified until out_valid. Verification compares results only when out_valid=1.
  - Reset mid-RUN or mid-DONE: the operation is discarded and all outputs are cleared as above. The first operation after reset release is computed correctly.
  - a == b gives diff=0, zero=1, borrow=0.
  - b == 0 gives borrow=0 (the final carry is 1).

Decomposition:
- Package int_sub_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default N and CHUNK;
  - the NCH and index-width constants.
- One sub-module, sub_chunk_cla: combinational CHUNK-bit carry-lookahead slice.
  - Inputs: x, y, cin.
  - Outputs: s, cout.
  - Built from g/p expansion. Instantiated once and multiplexed by index.

Test Plan:
1. a=5, b=3, out_ready=1 -> diff=2, borrow=0, zero=0, neg=0, ovf=0. out_valid exactly 8 edges after accept.
2. a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, neg=1, ovf=0, zero=0.
3. a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, neg=0, borrow=0. Also a=0x00010000, b=1 -> diff=0x0000FFFF, borrow rippling across 4 slices.
4. a=b=0x12345678 -> diff=0, zero=1, borrow=0, ovf=0.
5. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands presented throughout.
   - Required: outputs stable, in_ready=0, second operation accepted only on the first IDLE edge after the out_ready handshake, and its result correct.
6. Reset mid-operation:
   - Stimulus: rst pulsed during RUN index 3.
   - Required: out_valid=0 and diff=0 immediately (asynchronous), in_ready=1 after release. The next operation a=10, b=20 gives diff=0xFFFFFFF6, borrow=1.
